// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg : shared sizing helpers and parameter legality limits for the FIFO
// Rev 1.0  : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package fifo_pkg;

  localparam int MIN_ENTRIES = 2;
  localparam int MAX_ENTRIES = 1024;
  localparam int MIN_WIDTH   = 1;
  localparam int MAX_WIDTH   = 256;

  // Level signals need one extra bit so that "completely full" is representable.
  function automatic int count_bits(input int entries);
    return $clog2(entries) + 1;
  endfunction

  function automatic bit params_legal(input int entries, input int width);
    return (entries >= MIN_ENTRIES) && (entries <= MAX_ENTRIES) &&
           ((entries & (entries - 1)) == 0) &&
           (width >= MIN_WIDTH) && (width <= MAX_WIDTH);
  endfunction

endpackage : fifo_pkg

`default_nettype wire

// File: rtl/fifo_ram.sv
// ---------------------------------------------------------------------------
// fifo_ram : nrOfEntries x bitWidth storage, clocked write, asynchronous read
// Rev 1.0  : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module fifo_ram #(
  parameter int  nrOfEntries = 16,
  parameter int  bitWidth    = 32,
  localparam int addrBits    = $clog2(nrOfEntries)
) (
  input  logic                clock,
  input  logic                writeEnable,
  input  logic [addrBits-1:0] writeAddr,
  input  logic [bitWidth-1:0] writeData,
  input  logic [addrBits-1:0] readAddr,
  output logic [bitWidth-1:0] readData
);

  // Contents are deliberately not reset; validity is tracked by the level logic.
  logic [bitWidth-1:0] mem_q [nrOfEntries];

  always_ff @(posedge clock) begin
    if (writeEnable) begin
      mem_q[writeAddr] <= writeData;
    end
  end

  assign readData = mem_q[readAddr];

endmodule : fifo_ram

`default_nettype wire

// File: rtl/fifo_level.sv
// ---------------------------------------------------------------------------
// fifo_level : show-ahead synchronous FIFO with level, watermark and sticky
//              overflow/underflow flags; all flags derive from a registered count
// Rev 1.0    : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module fifo_level
  import fifo_pkg::*;
#(
  parameter int  nrOfEntries = 16,
  parameter int  bitWidth    = 32,
  localparam int countBits   = count_bits(nrOfEntries)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 flush,
  input  logic                 clearErrors,
  input  logic [bitWidth-1:0]  pushData,
  input  logic [countBits-1:0] almostFullLevel,
  input  logic [countBits-1:0] almostEmptyLevel,
  output logic [bitWidth-1:0]  popData,
  output logic                 full,
  output logic                 empty,
  output logic                 almostFull,
  output logic                 almostEmpty,
  output logic [countBits-1:0] count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int                   ptrBits    = $clog2(nrOfEntries);
  localparam logic [countBits-1:0] FULL_LEVEL = countBits'(nrOfEntries);

  if (!params_legal(nrOfEntries, bitWidth)) begin : g_param_check
    $error("fifo_level: illegal nrOfEntries=%0d / bitWidth=%0d", nrOfEntries, bitWidth);
  end

  logic [ptrBits-1:0]   readPtr_q,  readPtr_d;
  logic [ptrBits-1:0]   writePtr_q, writePtr_d;
  logic [countBits-1:0] count_q,    count_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;

  logic                 isFull;
  logic                 isEmpty;
  logic                 pushAccept;
  logic                 popAccept;
  logic                 overflowSet;
  logic                 underflowSet;
  logic                 writeEnable;
  logic [bitWidth-1:0]  ramData;

  always_comb begin
    isFull       = (count_q == FULL_LEVEL);
    isEmpty      = (count_q == '0);
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    pushAccept   = push & (~isFull | pop) & ~flush;
    popAccept    = pop & ~isEmpty & ~flush;
    overflowSet  = push & isFull & ~pop & ~flush;
    underflowSet = pop & isEmpty & ~flush;
  end

  always_comb begin
    readPtr_d   = readPtr_q;
    writePtr_d  = writePtr_q;
    count_d     = count_q;
    if (flush) begin
      readPtr_d  = '0;
      writePtr_d = '0;
      count_d    = '0;
    end else begin
      // Power-of-two depth lets the pointers wrap naturally.
      readPtr_d  = readPtr_q + ptrBits'(popAccept);
      writePtr_d = writePtr_q + ptrBits'(pushAccept);
      count_d    = count_q + countBits'(pushAccept) - countBits'(popAccept);
    end
    overflow_d  = overflowSet  | (overflow_q  & ~clearErrors);
    underflow_d = underflowSet | (underflow_q & ~clearErrors);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      readPtr_q   <= '0;
      writePtr_q  <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      readPtr_q   <= readPtr_d;
      writePtr_q  <= writePtr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign writeEnable = pushAccept & ~reset;

  fifo_ram #(
    .nrOfEntries (nrOfEntries),
    .bitWidth    (bitWidth)
  ) u_ram (
    .clock       (clock),
    .writeEnable (writeEnable),
    .writeAddr   (writePtr_q),
    .writeData   (pushData),
    .readAddr    (readPtr_q),
    .readData    (ramData)
  );

  // Masking on empty keeps stale storage from ever reaching the output.
  assign popData     = isEmpty ? '0 : ramData;
  assign full        = isFull;
  assign empty       = isEmpty;
  assign almostFull  = (count_q >= almostFullLevel);
  assign almostEmpty = (count_q <= almostEmptyLevel);
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule : fifo_level

`default_nettype wire

// File: tb/tb_fifo_level.sv
// ---------------------------------------------------------------------------
// tb_fifo_level : table vectors, directed corner sequences and a random run
//                 against a queue reference model for fifo_level (16 x 32)
// Rev 1.0       : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fifo_level;

  localparam int DEPTH = 16;
  localparam int WIDTH = 32;
  localparam int CB    = 5;

  logic             clock = 1'b0;
  logic             reset, push, pop, flush, clearErrors;
  logic [WIDTH-1:0] pushData, popData;
  logic [CB-1:0]    almostFullLevel, almostEmptyLevel, count;
  logic             full, empty, almostFull, almostEmpty, overflow, underflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] sb[$];
  bit               m_ovf, m_unf;

  always #5 clock = ~clock;

  fifo_level #(.nrOfEntries(DEPTH), .bitWidth(WIDTH)) dut (
    .clock            (clock),
    .reset            (reset),
    .push             (push),
    .pop              (pop),
    .flush            (flush),
    .clearErrors      (clearErrors),
    .pushData         (pushData),
    .almostFullLevel  (almostFullLevel),
    .almostEmptyLevel (almostEmptyLevel),
    .popData          (popData),
    .full             (full),
    .empty            (empty),
    .almostFull       (almostFull),
    .almostEmpty      (almostEmpty),
    .count            (count),
    .overflow         (overflow),
    .underflow        (underflow)
  );

  typedef struct packed {
    bit         ps, pp, fl, cl;
    logic [31:0] d;
    logic [4:0]  c;
    bit         e, f, af, ae, ov, un;
    logic [31:0] pd;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, check show-ahead data on pops, then advance the model.
  task automatic apply(input bit rs, input bit ps, input bit pp, input bit fl,
                       input bit cl, input logic [WIDTH-1:0] d);
    bit m_full, m_empty, pa, pk;
    reset = rs; push = ps; pop = pp; flush = fl; clearErrors = cl; pushData = d;
    #3;
    if (!rs && !fl && pp && sb.size() > 0) chk("pop_data", popData, sb[0]);
    @(posedge clock);
    #1;
    if (rs) begin
      sb.delete(); m_ovf = 0; m_unf = 0;
    end else if (fl) begin
      sb.delete();
      if (cl) begin m_ovf = 0; m_unf = 0; end
    end else begin
      m_full  = (sb.size() == DEPTH);
      m_empty = (sb.size() == 0);
      pa = ps && (!m_full || pp);
      pk = pp && !m_empty;
      m_ovf = (ps && m_full && !pp) || (m_ovf && !cl);
      m_unf = (pp && m_empty) || (m_unf && !cl);
      if (pk) void'(sb.pop_front());
      if (pa) sb.push_back(d);
    end
    reset = 0; push = 0; pop = 0; flush = 0; clearErrors = 0;
  endtask

  task automatic check_model();
    int n;
    n = sb.size();
    chk("m_count", WIDTH'(count), WIDTH'(n));
    chk("m_empty", WIDTH'(empty), WIDTH'(n == 0));
    chk("m_full", WIDTH'(full), WIDTH'(n == DEPTH));
    chk("m_afull", WIDTH'(almostFull), WIDTH'(n >= int'(almostFullLevel)));
    chk("m_aempty", WIDTH'(almostEmpty), WIDTH'(n <= int'(almostEmptyLevel)));
    chk("m_popdata", popData, (n == 0) ? '0 : sb[0]);
    chk("m_overflow", WIDTH'(overflow), WIDTH'(m_ovf));
    chk("m_underflow", WIDTH'(underflow), WIDTH'(m_unf));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //          ps pp fl cl data          c  e  f af ae ov un popData
    tbl[0] = '{1, 0, 0, 0, 32'hA1, 5'd1, 0, 0, 0, 1, 0, 0, 32'hA1};
    tbl[1] = '{1, 0, 0, 0, 32'hA2, 5'd2, 0, 0, 1, 0, 0, 0, 32'hA1};
    tbl[2] = '{0, 1, 0, 0, 32'h00, 5'd1, 0, 0, 0, 1, 0, 0, 32'hA2};
    tbl[3] = '{0, 1, 0, 0, 32'h00, 5'd0, 1, 0, 0, 1, 0, 0, 32'h00};
    tbl[4] = '{0, 1, 0, 0, 32'h00, 5'd0, 1, 0, 0, 1, 0, 1, 32'h00};
    tbl[5] = '{1, 1, 0, 0, 32'hA5, 5'd1, 0, 0, 0, 1, 0, 1, 32'hA5};
    tbl[6] = '{0, 0, 0, 1, 32'h00, 5'd1, 0, 0, 0, 1, 0, 0, 32'hA5};
    tbl[7] = '{1, 1, 0, 0, 32'hB1, 5'd1, 0, 0, 0, 1, 0, 0, 32'hB1};
    tbl[8] = '{1, 0, 1, 0, 32'hC1, 5'd0, 1, 0, 0, 1, 0, 0, 32'h00};

    reset = 1; push = 0; pop = 0; flush = 0; clearErrors = 0; pushData = '0;
    almostFullLevel = 5'd0; almostEmptyLevel = 5'd0;
    m_ovf = 0; m_unf = 0;
    repeat (2) @(posedge clock);
    #1;
    apply(1, 0, 0, 0, 0, '0);

    // Reset state
    chk("rst_count", WIDTH'(count), 0);
    chk("rst_empty", WIDTH'(empty), 1);
    chk("rst_full", WIDTH'(full), 0);
    chk("rst_popdata", popData, 0);
    chk("rst_aempty", WIDTH'(almostEmpty), 1);
    chk("rst_afull_lvl0", WIDTH'(almostFull), 1);
    almostFullLevel = 5'd5;
    #1;
    chk("rst_afull_lvl5", WIDTH'(almostFull), 0);
    chk("rst_flags", WIDTH'({overflow, underflow}), 0);

    // Table vectors
    almostFullLevel = 5'd2; almostEmptyLevel = 5'd1;
    for (int i = 0; i < 9; i++) begin
      apply(0, tbl[i].ps, tbl[i].pp, tbl[i].fl, tbl[i].cl, tbl[i].d);
      chk($sformatf("tbl%0d_count", i), WIDTH'(count), WIDTH'(tbl[i].c));
      chk($sformatf("tbl%0d_empty", i), WIDTH'(empty), WIDTH'(tbl[i].e));
      chk($sformatf("tbl%0d_full", i), WIDTH'(full), WIDTH'(tbl[i].f));
      chk($sformatf("tbl%0d_afull", i), WIDTH'(almostFull), WIDTH'(tbl[i].af));
      chk($sformatf("tbl%0d_aempty", i), WIDTH'(almostEmpty), WIDTH'(tbl[i].ae));
      chk($sformatf("tbl%0d_ovf", i), WIDTH'(overflow), WIDTH'(tbl[i].ov));
      chk($sformatf("tbl%0d_unf", i), WIDTH'(underflow), WIDTH'(tbl[i].un));
      chk($sformatf("tbl%0d_popdata", i), popData, tbl[i].pd);
    end

    // Fill, almostFull at 12, overflow, ordered drain, clear
    apply(1, 0, 0, 0, 0, '0);
    almostFullLevel = 5'd12; almostEmptyLevel = 5'd3;
    for (int i = 1; i <= DEPTH; i++) begin
      apply(0, 1, 0, 0, 0, WIDTH'(i));
      chk($sformatf("fill_afull_%0d", i), WIDTH'(almostFull), WIDTH'(i >= 12));
    end
    chk("fill_count", WIDTH'(count), 16);
    chk("fill_full", WIDTH'(full), 1);
    apply(0, 1, 0, 0, 0, 32'hDEAD);
    chk("ovf_set", WIDTH'(overflow), 1);
    chk("ovf_count", WIDTH'(count), 16);
    for (int i = 0; i < DEPTH; i++) apply(0, 0, 1, 0, 0, '0);
    chk("drain_empty", WIDTH'(empty), 1);
    chk("drain_ovf_sticky", WIDTH'(overflow), 1);
    apply(0, 0, 0, 0, 1, '0);
    chk("ovf_clear", WIDTH'(overflow), 0);
    check_model();

    // Push+pop while full, then drain across the wrap
    for (int i = 1; i <= DEPTH; i++) apply(0, 1, 0, 0, 0, WIDTH'(i));
    apply(0, 1, 1, 0, 0, 32'h99);
    chk("pp_full_count", WIDTH'(count), 16);
    chk("pp_full_ovf", WIDTH'(overflow), 0);
    chk("pp_full_head", popData, 32'h2);
    for (int i = 0; i < DEPTH - 1; i++) apply(0, 0, 1, 0, 0, '0);
    chk("wrap_last", popData, 32'h99);
    apply(0, 0, 1, 0, 0, '0);
    check_model();

    // Flush with push at count 7, error flags untouched; reset mid-fill
    apply(0, 0, 1, 0, 0, '0);
    for (int i = 0; i < 7; i++) apply(0, 1, 0, 0, 0, 32'h100 + WIDTH'(i));
    chk("pre_flush_count", WIDTH'(count), 7);
    apply(0, 1, 0, 1, 0, 32'hF00D);
    chk("flush_count", WIDTH'(count), 0);
    chk("flush_empty", WIDTH'(empty), 1);
    chk("flush_popdata", popData, 0);
    chk("flush_unf_kept", WIDTH'(underflow), 1);
    for (int i = 0; i < 3; i++) apply(0, 1, 0, 0, 0, 32'h200 + WIDTH'(i));
    apply(1, 1, 0, 0, 0, 32'h300);
    chk("rstmid_count", WIDTH'(count), 0);
    chk("rstmid_unf", WIDTH'(underflow), 0);
    chk("rstmid_popdata", popData, 0);
    apply(0, 1, 0, 0, 0, 32'h77);
    chk("rstmid_fresh", popData, 32'h77);
    check_model();

    // Random traffic against the reference queue
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        almostFullLevel  = CB'($urandom_range(0, DEPTH));
        almostEmptyLevel = CB'($urandom_range(0, DEPTH));
      end
      apply($urandom_range(0, 999) < 3,
            $urandom_range(0, 99) < 55,
            $urandom_range(0, 99) < 50,
            $urandom_range(0, 99) < 1,
            $urandom_range(0, 99) < 3,
            $urandom());
      check_model();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fifo_level

`default_nettype wire
